// File: rtl/rx_comando_valvula.sv
// UART receiver and command decoder for the tank controller host link.
// Optional even-parity frames (8E1) are enabled by defining RX_PARIDADE_EN.
`timescale 1ns/1ps
module rx_comando_valvula #(
  parameter int BAUD_DIV       = 434,
  parameter int TIMEOUT_CICLOS = 500_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] dado,
  output logic       dado_valido,
  output logic       erro_quadro,
  output logic       manual,
  output logic       abre_manual,
  output logic       cmd_invalido,
  output logic [2:0] db_estado_rx
);

  localparam int TW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int WW = $clog2(TIMEOUT_CICLOS);

  localparam logic [TW-1:0] T_HALF = TW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(BAUD_DIV - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CICLOS - 1);

  localparam logic [7:0] CMD_M = 8'h4D;
  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_F = 8'h46;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    STOP     = 3'd4
  } estado_e;

  logic          rx_meta_q;
  logic          rx_s_q;
  logic          rx_s;

  estado_e       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    dado_q, dado_d;
  logic          dv_q, dv_d;
  logic          erro_q, erro_d;
  logic          par_fail;

  logic          manual_q, manual_d;
  logic          abre_q, abre_d;
  logic          ci_q, ci_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    cmd;

  logic          tick_half;
  logic          tick_bit;

  // Synchronizer presets to idle-high so reset never looks like a start bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign rx_s = rx_s_q;

  assign tick_half = (timer_q == T_HALF);
  assign tick_bit  = (timer_q == T_BIT);

`ifdef RX_PARIDADE_EN
  logic par_q, par_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end

  assign par_fail = par_q;
`else
  assign par_fail = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    dado_d   = dado_q;
    dv_d     = 1'b0;
    erro_d   = 1'b0;
`ifdef RX_PARIDADE_EN
    par_d    = par_q;
`endif
    unique case (estado_q)
      IDLE: begin
        if (!rx_s) begin
          estado_d = START;
          timer_d  = '0;
        end
      end
      START: begin
        if (tick_half) begin
          timer_d = '0;
          if (rx_s) begin
            estado_d = IDLE;
          end else begin
            estado_d = DADOS;
            idx_d    = 3'd0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DADOS: begin
        if (tick_bit) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef RX_PARIDADE_EN
            estado_d = PARIDADE;
`else
            estado_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef RX_PARIDADE_EN
      PARIDADE: begin
        if (tick_bit) begin
          timer_d  = '0;
          // Even parity: data plus parity bit must have an even count of ones
          par_d    = ^{shift_q, rx_s};
          estado_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick_bit) begin
          timer_d  = '0;
          estado_d = IDLE;
          if (rx_s && !par_fail) begin
            dado_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            erro_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        estado_d = IDLE;
        timer_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      dado_q   <= '0;
      dv_q     <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      dado_q   <= dado_d;
      dv_q     <= dv_d;
      erro_q   <= erro_d;
    end
  end

  // Clearing bit 5 folds lowercase letters onto uppercase
  assign cmd = dado_q & 8'hDF;

  always_comb begin
    manual_d = manual_q;
    abre_d   = abre_q;
    ci_d     = 1'b0;
    wd_d     = wd_q;
    if (dv_q) begin
      wd_d = '0;
      case (cmd)
        CMD_M: manual_d = 1'b1;
        CMD_A: begin
          manual_d = 1'b0;
          abre_d   = 1'b0;
        end
        CMD_B: begin
          if (manual_q) abre_d = 1'b1;
        end
        CMD_F: abre_d = 1'b0;
        default: ci_d = 1'b1;
      endcase
    end else if (!manual_q) begin
      wd_d = '0;
    end else if (wd_q == WD_MAX) begin
      manual_d = 1'b0;
      abre_d   = 1'b0;
      wd_d     = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      manual_q <= 1'b0;
      abre_q   <= 1'b0;
      ci_q     <= 1'b0;
      wd_q     <= '0;
    end else begin
      manual_q <= manual_d;
      abre_q   <= abre_d;
      ci_q     <= ci_d;
      wd_q     <= wd_d;
    end
  end

  assign dado         = dado_q;
  assign dado_valido  = dv_q;
  assign erro_quadro  = erro_q;
  assign manual       = manual_q;
  assign abre_manual  = abre_q;
  assign cmd_invalido = ci_q;
  assign db_estado_rx = estado_q;

endmodule

// File: tb/tb_rx_comando_valvula.sv
// Bench for rx_comando_valvula: vector table, corner sequences, random frames.
// Honours RX_PARIDADE_EN so frames match the receiver build.
`timescale 1ns/1ps
module tb_rx_comando_valvula;

  localparam int BD = 4;
  localparam int TO = 200;
`ifdef RX_PARIDADE_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       RX    = 1'b1;
  logic [7:0] dado;
  logic       dado_valido;
  logic       erro_quadro;
  logic       manual;
  logic       abre_manual;
  logic       cmd_invalido;
  logic [2:0] db_estado_rx;

  rx_comando_valvula #(
    .BAUD_DIV(BD),
    .TIMEOUT_CICLOS(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .RX(RX),
    .dado(dado),
    .dado_valido(dado_valido),
    .erro_quadro(erro_quadro),
    .manual(manual),
    .abre_manual(abre_manual),
    .cmd_invalido(cmd_invalido),
    .db_estado_rx(db_estado_rx)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int dv_cnt = 0;
  int er_cnt = 0;
  int ci_cnt = 0;
  int low_cnt = 0;
  int st_cnt = 0;
  int last_dv = 0;

  always @(negedge clock) begin
    cyc++;
    if (dado_valido) begin
      dv_cnt++;
      last_dv = cyc;
    end
    if (erro_quadro) er_cnt++;
    if (cmd_invalido) ci_cnt++;
    if (!manual) low_cnt++;
    if (db_estado_rx == 3'd1) st_cnt++;
  end

  // Reference state of the host-link controls
  logic [7:0] m_dado = 8'h00;
  bit         m_man  = 1'b0;
  bit         m_abre = 1'b0;

  typedef struct {
    logic [7:0] b;
    bit         stop;
    logic [7:0] e_dado;
    int         e_dv;
    int         e_er;
    int         e_ci;
    bit         e_man;
    bit         e_abre;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop,
                      input bit pb, input int ncyc);
    logic bits [12];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    nb = 9;
    if (PAR) begin
      bits[9] = (^b) ^ pb;
      nb = 10;
    end
    bits[nb] = stop;
    nb++;
    @(posedge clock);
    #1;
    for (int c = 0; c < nb * BD && c < ncyc; c++) begin
      RX = bits[c / BD];
      @(posedge clock);
      #1;
    end
    RX = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit stop, input bit pb,
                           input int gap, output int ddv, output int der,
                           output int dci);
    int dv0;
    int er0;
    int ci0;
    dv0 = dv_cnt;
    er0 = er_cnt;
    ci0 = ci_cnt;
    send(b, stop, pb, 1000);
    tick(gap);
    @(negedge clock);
    #1;
    ddv = dv_cnt - dv0;
    der = er_cnt - er0;
    dci = ci_cnt - ci0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok,
                             output int edv, output int eer, output int eci);
    logic [7:0] up;
    edv = 0;
    eer = 0;
    eci = 0;
    if (!ok) begin
      eer = 1;
    end else begin
      edv    = 1;
      m_dado = b;
      up     = b & 8'hDF;
      case (up)
        8'h4D: m_man = 1'b1;
        8'h41: begin
          m_man  = 1'b0;
          m_abre = 1'b0;
        end
        8'h42: if (m_man) m_abre = 1'b1;
        8'h46: m_abre = 1'b0;
        default: eci = 1;
      endcase
    end
  endtask

  task automatic model_check(input string tag, input logic [7:0] b,
                             input bit stop, input bit pb, input int gap);
    int ddv, der, dci, edv, eer, eci;
    run_frame(b, stop, pb, gap, ddv, der, dci);
    model_frame(b, stop && !pb, edv, eer, eci);
    check({tag, "_dado"}, dado, m_dado);
    check({tag, "_dv"}, ddv, edv);
    check({tag, "_erro"}, der, eer);
    check({tag, "_cmdinv"}, dci, eci);
    check({tag, "_manual"}, manual, m_man);
    check({tag, "_abre"}, abre_manual, m_abre);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    m_dado = 8'h00;
    m_man  = 1'b0;
    m_abre = 1'b0;
    tick(3);
  endtask

  logic [7:0] cmds [8];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int ddv, der, dci, k, st0, low0, consec, fall;
    logic [7:0] b;
    bit stop, pb;

    cmds = '{8'h4D, 8'h6D, 8'h41, 8'h61, 8'h42, 8'h62, 8'h46, 8'h66};

    //            byte  stop dado   dv er ci man abre
    tbl[0]  = '{8'h4D, 1, 8'h4D, 1, 0, 0, 1, 0};
    tbl[1]  = '{8'h6D, 1, 8'h6D, 1, 0, 0, 1, 0};
    tbl[2]  = '{8'h62, 1, 8'h62, 1, 0, 0, 1, 1};
    tbl[3]  = '{8'h66, 1, 8'h66, 1, 0, 0, 1, 0};
    tbl[4]  = '{8'h41, 1, 8'h41, 1, 0, 0, 0, 0};
    tbl[5]  = '{8'h42, 1, 8'h42, 1, 0, 0, 0, 0};
    tbl[6]  = '{8'h5A, 1, 8'h5A, 1, 0, 1, 0, 0};
    tbl[7]  = '{8'h41, 0, 8'h5A, 0, 1, 0, 0, 0};
    tbl[8]  = '{8'h4D, 1, 8'h4D, 1, 0, 0, 1, 0};
    tbl[9]  = '{8'h42, 1, 8'h42, 1, 0, 0, 1, 1};
    tbl[10] = '{8'h61, 1, 8'h61, 1, 0, 0, 0, 0};
    tbl[11] = '{8'h4D, 1, 8'h4D, 1, 0, 0, 1, 0};
    tbl[12] = '{8'h62, 1, 8'h62, 1, 0, 0, 1, 1};
    tbl[13] = '{8'h4D, 1, 8'h4D, 1, 0, 0, 1, 1};
    tbl[14] = '{8'h5A, 1, 8'h5A, 1, 0, 1, 1, 1};
    tbl[15] = '{8'h41, 1, 8'h41, 1, 0, 0, 0, 0};

    tick(3);
    @(negedge clock);
    check("reset_outputs",
          {dado, dado_valido, erro_quadro, manual, abre_manual,
           cmd_invalido}, 0);
    check("reset_state", db_estado_rx, 0);
    reset = 1'b0;
    tick(3);

    for (int i = 0; i < 16; i++) begin
      run_frame(tbl[i].b, tbl[i].stop, 1'b0, 5, ddv, der, dci);
      check($sformatf("tbl%0d_dado", i), dado, tbl[i].e_dado);
      check($sformatf("tbl%0d_dv", i), ddv, tbl[i].e_dv);
      check($sformatf("tbl%0d_erro", i), der, tbl[i].e_er);
      check($sformatf("tbl%0d_cmdinv", i), dci, tbl[i].e_ci);
      check($sformatf("tbl%0d_manual", i), manual, tbl[i].e_man);
      check($sformatf("tbl%0d_abre", i), abre_manual, tbl[i].e_abre);
      model_frame(tbl[i].b, tbl[i].stop, ddv, der, dci);
    end

    // One-cycle low glitch is a false start
    st0 = st_cnt;
    ddv = dv_cnt;
    der = er_cnt;
    @(posedge clock);
    #1;
    RX = 1'b0;
    @(posedge clock);
    #1;
    RX = 1'b1;
    tick(10);
    @(negedge clock);
    #1;
    check("glitch_saw_start", (st_cnt - st0) > 0, 1);
    check("glitch_no_dv", dv_cnt - ddv, 0);
    check("glitch_no_erro", er_cnt - der, 0);
    check("glitch_idle", db_estado_rx, 0);

    // Watchdog timeout measured from the last dado_valido
    model_check("wd_m", 8'h4D, 1'b1, 1'b0, 5);
    model_check("wd_b", 8'h62, 1'b1, 1'b0, 5);
    fall = -1;
    for (k = 0; k < 400; k++) begin
      @(negedge clock);
      #1;
      if (!manual) begin
        fall = cyc - last_dv;
        break;
      end
    end
    check("wd_timeout_cycles", fall, TO + 1);
    check("wd_abre_cleared", abre_manual, 0);
    m_man  = 1'b0;
    m_abre = 1'b0;

    // Keep-alive: 'F' every 150 cycles holds manual mode
    model_check("ka_m", 8'h4D, 1'b1, 1'b0, 5);
    low0 = low_cnt;
    for (int i = 0; i < 4; i++) begin
      tick(109);
      send(8'h46, 1'b1, 1'b0, 1000);
      model_frame(8'h46, 1'b1, ddv, der, dci);
    end
    tick(5);
    @(negedge clock);
    #1;
    check("ka_manual_never_low", low_cnt - low0, 0);
    check("ka_manual", manual, 1);

    // Reset mid-frame aborts the receiver
    send(8'h42, 1'b1, 1'b0, 20);
    @(negedge clock);
    check("mid_state_dados", db_estado_rx, 2);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs",
          {dado, dado_valido, erro_quadro, manual, abre_manual,
           cmd_invalido, db_estado_rx}, 0);
    tick(2);
    reset = 1'b0;
    m_dado = 8'h00;
    m_man  = 1'b0;
    m_abre = 1'b0;
    tick(2);
    model_check("post_reset", 8'h4D, 1'b1, 1'b0, 5);

`ifdef RX_PARIDADE_EN
    model_check("par_bad", 8'h42, 1'b1, 1'b1, 5);
    model_check("par_ok", 8'h42, 1'b1, 1'b0, 5);
`endif

    // Randomized frames against the reference model
    do_reset();
    consec = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8) b = cmds[$urandom_range(0, 7)];
      else b = 8'($urandom);
      stop = 1'b1;
      pb   = 1'b0;
      if (consec < 2 && $urandom_range(0, 9) == 0) begin
        if (PAR && $urandom_range(0, 1) == 1) pb = 1'b1;
        else stop = 1'b0;
        consec++;
      end else begin
        consec = 0;
      end
      model_check($sformatf("rnd%0d", i), b, stop, pb,
                  int'($urandom_range(5, 10)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
